// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial main RAM controller.
// State, length and grant encodings plus length normalisation.
package mem_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IRD  = 2'd1;
  localparam logic [1:0] ST_DRD  = 2'd2;
  localparam logic [1:0] ST_DWR  = 2'd3;

  localparam logic [2:0] LEN_BYTE = 3'd1;
  localparam logic [2:0] LEN_HALF = 3'd2;
  localparam logic [2:0] LEN_WORD = 3'd4;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  // Any byte count other than 1 or 2 becomes a full word.
  function automatic logic [2:0] norm_len(
    input logic [2:0] l
  );
    if (l == LEN_BYTE || l == LEN_HALF)
      return l;
    return LEN_WORD;
  endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// Grant logic between icache refills and data accesses.
// Round-robin on conflict; no grant while busy or in a done cycle.
module mem_ctrl_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic inst_needed,
  input  logic data_req,
  input  logic last_grant,
  input  logic busy,
  input  logic done_cycle,
  output logic grant_inst,
  output logic grant_data
);

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!busy && !done_cycle) begin
      unique case (1'b1)
        inst_needed && data_req: begin
          if (last_grant == GRANT_DATA)
            grant_inst = 1'b1;
          else
            grant_data = 1'b1;
        end
        inst_needed && !data_req:
          grant_inst = 1'b1;
        data_req && !inst_needed:
          grant_data = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Sole master of the byte-wide main RAM: serialises 1/2/4-byte
// accesses into byte cycles and assembles little-endian words.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_needed,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_avail,
  output logic [WORD_W-1:0] inst_word,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [2:0]        data_len,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [WORD_W-1:0] data_wdata,
  output logic              data_done,
  output logic [WORD_W-1:0] data_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic [2:0]        len;
  logic [ADDR_W-1:0] base;
  logic [WORD_W-1:0] wbuf;
  logic [WORD_W-1:0] rbuf;
  logic [WORD_W-1:0] rbuf_nxt;
  logic              last_grant;
  logic              grant_inst;
  logic              grant_data;
  logic              busy;
  logic              done_cycle;
  logic              is_rd;
  logic              rd_last;
  logic              wr_last;
  logic              inst_abort;
  logic [1:0]        rd_idx;
  logic [ADDR_W-1:0] cur_a;

  assign busy       = (state != ST_IDLE);
  assign done_cycle = inst_avail | data_done;
  assign is_rd      = (state == ST_IRD) || (state == ST_DRD);
  assign rd_last    = (cnt == len);
  assign wr_last    = (cnt == 3'(len - 3'd1));
  assign rd_idx     = cnt[1:0] - 2'd1;
  assign cur_a      = base + ADDR_W'(cnt);
  assign inst_abort = (state == ST_IRD) &&
                      (!inst_needed || inst_addr != base);

  mem_ctrl_arbiter u_arb (
    .inst_needed (inst_needed),
    .data_req    (data_req),
    .last_grant  (last_grant),
    .busy        (busy),
    .done_cycle  (done_cycle),
    .grant_inst  (grant_inst),
    .grant_data  (grant_data)
  );

  // Byte k-1 arrives on mem_din during counter step k.
  always_comb begin
    rbuf_nxt = rbuf;
    if (is_rd && cnt != 3'd0)
      rbuf_nxt[{rd_idx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    unique case (state)
      ST_IRD, ST_DRD: begin
        if (cnt < len)
          mem_a = cur_a;
      end
      ST_DWR: begin
        mem_a    = cur_a;
        mem_wr   = 1'b1;
        mem_dout = wbuf[{cnt[1:0], 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      len        <= '0;
      base       <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
      last_grant <= GRANT_DATA;
      inst_avail <= 1'b0;
      inst_word  <= '0;
      data_done  <= 1'b0;
      data_rdata <= '0;
    end else begin
      inst_avail <= 1'b0;
      data_done  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (grant_inst) begin
            state      <= ST_IRD;
            base       <= inst_addr;
            len        <= LEN_WORD;
            rbuf       <= '0;
            last_grant <= GRANT_INST;
          end else if (grant_data) begin
            state      <= data_we ? ST_DWR : ST_DRD;
            base       <= data_addr;
            len        <= norm_len(data_len);
            wbuf       <= data_wdata;
            rbuf       <= '0;
            last_grant <= GRANT_DATA;
          end
        end
        ST_IRD: begin
          if (inst_abort) begin
            state <= ST_IDLE;
          end else begin
            rbuf <= rbuf_nxt;
            if (rd_last) begin
              state      <= ST_IDLE;
              inst_avail <= 1'b1;
              inst_word  <= rbuf_nxt;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        ST_DRD: begin
          rbuf <= rbuf_nxt;
          if (rd_last) begin
            state      <= ST_IDLE;
            data_done  <= 1'b1;
            data_rdata <= rbuf_nxt;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_DWR: begin
          if (wr_last) begin
            state     <= ST_IDLE;
            data_done <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl against a byte-array RAM
// and a transaction-level reference model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_needed = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_avail;
  logic [31:0] inst_word;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [2:0]  data_len = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_done;
  logic [31:0] data_rdata;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  ram    [logic [31:0]];
  logic [7:0]  shadow [logic [31:0]];
  logic [31:0] tr_a   [16];
  logic        tr_wr  [16];
  logic [7:0]  tr_do  [16];
  logic [31:0] prev_rd = '0;

  mem_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst_needed (inst_needed),
    .inst_addr   (inst_addr),
    .inst_avail  (inst_avail),
    .inst_word   (inst_word),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_len    (data_len),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_done   (data_done),
    .data_rdata  (data_rdata),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .mem_a       (mem_a),
    .mem_wr      (mem_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bkg(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : bkg(a);
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : bkg(a);
  endfunction

  function automatic int eff_len(input logic [2:0] l);
    return (l == 3'd1 || l == 3'd2) ? int'(l) : 4;
  endfunction

  function automatic logic [31:0] model_word(
    input logic [31:0] a, input int n
  );
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++)
      w[8*i +: 8] = sh_rd(a + 32'(i));
    return w;
  endfunction

  // RAM: synchronous write, read data valid the cycle after the address.
  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr)
      ram[mem_a] = mem_dout;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    inst_needed = 1'b0;
    data_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic data_txn(
    input  logic        we,
    input  logic [2:0]  len,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output int          lat
  );
    int c;
    c = 0;
    lat = -1;
    data_req = 1'b1;
    data_we = we;
    data_len = len;
    data_addr = addr;
    data_wdata = wd;
    while (c < 40) begin
      @(negedge clk);
      if (c < 16) begin
        tr_a[c] = mem_a;
        tr_wr[c] = mem_wr;
        tr_do[c] = mem_dout;
      end
      if (data_done) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1 c++;
    end
    rd = data_rdata;
    data_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic inst_txn(
    input  logic [31:0] addr,
    output logic [31:0] word,
    output int          lat
  );
    int c;
    c = 0;
    lat = -1;
    inst_needed = 1'b1;
    inst_addr = addr;
    while (c < 40) begin
      @(negedge clk);
      if (c < 16) begin
        tr_a[c] = mem_a;
        tr_wr[c] = mem_wr;
        tr_do[c] = mem_dout;
      end
      if (inst_avail) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1 c++;
    end
    word = inst_word;
    inst_needed = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    inst_needed = 1'b1;
    data_req = 1'b1;
    inst_addr = 32'h1234;
    data_addr = 32'h5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({mem_a, mem_wr, mem_dout} !== '0) begin
      miscompares++;
      $display("FAIL reset_ram_if got a=%h wr=%b do=%h want 0",
               mem_a, mem_wr, mem_dout);
    end
    vectors++;
    if ({inst_avail, data_done, inst_word, data_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs got ia=%b dd=%b iw=%h dr=%h want 0",
               inst_avail, data_done, inst_word, data_rdata);
    end
    inst_needed = 1'b0;
    data_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mem_a, mem_wr, inst_avail, data_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_idle got a=%h wr=%b want 0", mem_a, mem_wr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_inst_fetch();
    logic [31:0] w;
    int lat;
    inst_txn(32'h100, w, lat);
    vectors++;
    if (lat !== 6) begin
      miscompares++;
      $display("FAIL ifetch_latency got %0d want 6", lat);
    end
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (tr_a[i] !== 32'h100 + 32'(i - 1) || tr_wr[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL ifetch_addr cyc%0d got %h/%b want %h/0",
                 i, tr_a[i], tr_wr[i], 32'h100 + 32'(i - 1));
      end
    end
    vectors++;
    if (w !== 32'h00100513) begin
      miscompares++;
      $display("FAIL ifetch_word got %h want 00100513", w);
    end
    @(negedge clk);
    vectors++;
    if (inst_avail !== 1'b0 || inst_word !== 32'h00100513) begin
      miscompares++;
      $display("FAIL ifetch_hold got ia=%b iw=%h want 0/00100513",
               inst_avail, inst_word);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    int lat;
    data_txn(1'b1, 3'd2, 32'h2000, 32'hAABBCCDD, rd, lat);
    shadow[32'h2000] = 8'hDD;
    shadow[32'h2001] = 8'hCC;
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("FAIL store_latency got %0d want 3", lat);
    end
    vectors++;
    if ({tr_wr[1], tr_a[1], tr_do[1]} !== {1'b1, 32'h2000, 8'hDD}) begin
      miscompares++;
      $display("FAIL store_b0 got %b %h %h want 1 2000 dd",
               tr_wr[1], tr_a[1], tr_do[1]);
    end
    vectors++;
    if ({tr_wr[2], tr_a[2], tr_do[2]} !== {1'b1, 32'h2001, 8'hCC}) begin
      miscompares++;
      $display("FAIL store_b1 got %b %h %h want 1 2001 cc",
               tr_wr[2], tr_a[2], tr_do[2]);
    end
    vectors++;
    if (tr_wr[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL store_stop got wr=%b want 0", tr_wr[3]);
    end
    data_txn(1'b0, 3'd1, 32'h2001, 32'h0, rd, lat);
    vectors++;
    if (rd !== 32'h000000CC || lat !== 3) begin
      miscompares++;
      $display("FAIL load_byte got %h lat %0d want 000000cc lat 3",
               rd, lat);
    end
    prev_rd = rd;
  endtask

  task automatic test_round_robin();
    int ev_c[$];
    int ev_k[$];
    int g;
    int who;
    int last;
    int d;
    do_reset();
    rst_n = 1'b0;
    inst_needed = 1'b1;
    inst_addr = 32'h100;
    data_req = 1'b1;
    data_we = 1'b0;
    data_len = 3'd1;
    data_addr = 32'h2001;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (inst_avail) begin
        ev_c.push_back(c);
        ev_k.push_back(0);
      end
      if (data_done) begin
        ev_c.push_back(c);
        ev_k.push_back(1);
      end
      @(posedge clk);
      #1;
    end
    vectors++;
    if (ev_c.size() < 4) begin
      miscompares++;
      $display("FAIL rr_count got %0d want >=4", ev_c.size());
    end
    g = 0;
    last = 1;
    for (int i = 0; i < 4 && i < ev_c.size(); i++) begin
      who = (last == 1) ? 0 : 1;
      d = g + ((who == 0) ? 6 : 3);
      vectors++;
      if (ev_k[i] !== who || ev_c[i] !== d) begin
        miscompares++;
        $display("FAIL rr_order ev%0d got kind %0d cyc %0d want %0d %0d",
                 i, ev_k[i], ev_c[i], who, d);
      end
      g = d + 1;
      last = who;
    end
    vectors++;
    if (inst_word !== 32'h00100513 || data_rdata !== 32'hCC) begin
      miscompares++;
      $display("FAIL rr_data got %h %h want 00100513 000000cc",
               inst_word, data_rdata);
    end
    do_reset();
    prev_rd = '0;
  endtask

  task automatic test_abort();
    int av_c;
    logic [31:0] a3;
    logic [31:0] exp;
    av_c = -1;
    a3 = 32'hDEAD;
    inst_needed = 1'b1;
    inst_addr = 32'h40;
    for (int c = 0; c < 20; c++) begin
      if (c == 2)
        inst_addr = 32'h80;
      @(negedge clk);
      if (c == 3)
        a3 = mem_a;
      if (inst_avail && av_c < 0)
        av_c = c;
      @(posedge clk);
      #1;
      if (av_c >= 0)
        inst_needed = 1'b0;
    end
    exp = model_word(32'h80, 4);
    vectors++;
    if (a3 !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_idle got a=%h want 0", a3);
    end
    vectors++;
    if (av_c !== 9 || inst_word !== exp) begin
      miscompares++;
      $display("FAIL abort_refetch got cyc %0d %h want 9 %h",
               av_c, inst_word, exp);
    end
  endtask

  task automatic test_reset_mid_store();
    int dn;
    dn = 0;
    data_req = 1'b1;
    data_we = 1'b1;
    data_len = 3'd4;
    data_addr = 32'h3000;
    data_wdata = 32'h11223344;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    data_req = 1'b0;
    #1;
    vectors++;
    if ({mem_wr, mem_a, mem_dout, data_done, data_rdata} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outs got wr=%b a=%h do=%h want 0",
               mem_wr, mem_a, mem_dout);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (data_done || mem_wr)
        dn++;
    end
    @(posedge clk);
    #1;
    shadow[32'h3000] = 8'h44;
    shadow[32'h3001] = 8'h33;
    vectors++;
    if (dn !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_done got %0d events want 0", dn);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ram_rd(32'h3000 + 32'(i)) !== sh_rd(32'h3000 + 32'(i))) begin
        miscompares++;
        $display("FAIL rst_mid_ram byte%0d got %h want %h", i,
                 ram_rd(32'h3000 + 32'(i)), sh_rd(32'h3000 + 32'(i)));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic [31:0] exp;
    int lat;
    exp = model_word(32'hFFFFFFFE, 4);
    data_txn(1'b0, 3'd4, 32'hFFFFFFFE, 32'h0, rd, lat);
    vectors++;
    if (tr_a[1] !== 32'hFFFFFFFE || tr_a[2] !== 32'hFFFFFFFF ||
        tr_a[3] !== 32'h0 || tr_a[4] !== 32'h1) begin
      miscompares++;
      $display("FAIL wrap_addr got %h %h %h %h want fffffffe ffffffff 0 1",
               tr_a[1], tr_a[2], tr_a[3], tr_a[4]);
    end
    vectors++;
    if (rd !== exp || lat !== 6) begin
      miscompares++;
      $display("FAIL wrap_data got %h lat %0d want %h lat 6", rd, lat, exp);
    end
    prev_rd = rd;
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    logic [2:0]  l;
    int lat;
    int n;
    int kind;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      a = 32'h5000 + 32'($urandom_range(0, 63));
      l = 3'($urandom_range(0, 7));
      wd = $urandom;
      n = eff_len(l);
      if (kind == 0) begin
        exp = model_word(a, 4);
        inst_txn(a, rd, lat);
        vectors++;
        if (rd !== exp || lat !== 6 || data_rdata !== prev_rd) begin
          miscompares++;
          $display("FAIL rnd_inst t%0d got %h lat %0d dr %h want %h 6 %h",
                   t, rd, lat, data_rdata, exp, prev_rd);
        end
      end else if (kind == 1) begin
        data_txn(1'b1, l, a, wd, rd, lat);
        for (int i = 0; i < n; i++)
          shadow[a + 32'(i)] = wd[8*i +: 8];
        vectors++;
        if (lat !== n + 1 || rd !== prev_rd) begin
          miscompares++;
          $display("FAIL rnd_store t%0d got lat %0d dr %h want %0d %h",
                   t, lat, rd, n + 1, prev_rd);
        end
      end else begin
        exp = model_word(a, n);
        data_txn(1'b0, l, a, 32'h0, rd, lat);
        vectors++;
        if (rd !== exp || lat !== n + 2) begin
          miscompares++;
          $display("FAIL rnd_load t%0d len %0d got %h lat %0d want %h %0d",
                   t, l, rd, lat, exp, n + 2);
        end
        prev_rd = exp;
      end
    end
  endtask

  initial begin
    ram[32'h100] = 8'h13;
    ram[32'h101] = 8'h05;
    ram[32'h102] = 8'h10;
    ram[32'h103] = 8'h00;
    shadow[32'h100] = 8'h13;
    shadow[32'h101] = 8'h05;
    shadow[32'h102] = 8'h10;
    shadow[32'h103] = 8'h00;
    test_reset();
    test_inst_fetch();
    test_store_load();
    test_round_robin();
    test_abort();
    test_reset_mid_store();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
